// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate response checker: op codes, FSM states and
// the reference result function used to predict the gate output.
package gate_chk_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_ADD  = 3'd6;

  localparam int unsigned MAX_W = 32;
  typedef logic [MAX_W-1:0] opnd_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  // Result is computed at MAX_W and masked to 'width'; callers truncate to width+1.
  function automatic logic [MAX_W:0] gate_expected(input logic [2:0] op,
                                                   input opnd_t a,
                                                   input opnd_t b,
                                                   input int unsigned width);
    opnd_t          mask;
    opnd_t          am;
    opnd_t          bm;
    logic [MAX_W:0] r;
    mask = opnd_t'((64'd1 << width) - 64'd1);
    am   = a & mask;
    bm   = b & mask;
    case (op)
      OP_OR:   r = {1'b0, am | bm};
      OP_XOR:  r = {1'b0, am ^ bm};
      OP_NAND: r = {1'b0, ~(am & bm) & mask};
      OP_NOR:  r = {1'b0, ~(am | bm) & mask};
      OP_XNOR: r = {1'b0, ~(am ^ bm) & mask};
      OP_ADD:  r = {1'b0, am} + {1'b0, bm};
      default: r = {1'b0, am & bm};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_chk_delay.sv
// LATENCY-stage shift register of {valid, expected} aligning predictions to
// the gate output; pass-through when LATENCY is 0.
module gate_chk_delay #(
  parameter int unsigned W       = 6,
  parameter int unsigned LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  generate
    if (LATENCY == 0) begin : g_pass
      logic unused_pass;
      assign unused_pass = ^{clk, rst_n, flush_i};
      assign valid_o     = valid_i;
      assign data_o      = data_i;
    end else begin : g_pipe
      logic [LATENCY-1:0] vld_q;
      logic [W-1:0]       dat_q [LATENCY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
          for (int unsigned i = 0; i < LATENCY; i++) dat_q[i] <= '0;
        end else if (flush_i) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= valid_i;
          dat_q[0] <= data_i;
          for (int unsigned i = 1; i < LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
          end
        end
      end

      assign valid_o = vld_q[LATENCY-1];
      assign data_o  = dat_q[LATENCY-1];
    end
  endgenerate

endmodule

// File: rtl/gate_resp_checker.sv
// Response checker for combinational gate blocks: predicts z, aligns it to the
// gate latency, counts mismatches, captures the first one and reports a verdict.
module gate_resp_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned NUM_VECTORS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [15:0]      vec_cnt,
  output logic [15:0]      err_cnt,
  output logic [15:0]      first_err_idx,
  output logic [WIDTH:0]   first_err_exp,
  output logic [WIDTH:0]   first_err_got
);

  localparam int unsigned ZW = WIDTH + 1;
  typedef logic [ZW-1:0] zval_t;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] vec_cnt_q, vec_cnt_d;
  logic [15:0] cmp_cnt_q, cmp_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [15:0] fidx_q, fidx_d;
  zval_t       fexp_q, fexp_d;
  zval_t       fgot_q, fgot_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        mism_q, mism_d;

  logic        accept;
  logic        dly_valid;
  logic        cmp_valid;
  logic        cmp_fail;
  zval_t       exp_now;
  zval_t       exp_dly;

  assign exp_now = zval_t'(gate_expected(op_q, opnd_t'(a), opnd_t'(b), WIDTH));

  gate_chk_delay #(
    .W       (ZW),
    .LATENCY (LATENCY)
  ) u_dly (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (start),
    .valid_i (accept),
    .data_i  (exp_now),
    .valid_o (dly_valid),
    .data_o  (exp_dly)
  );

  always_comb begin
    accept    = (state_q == ST_RUN) && in_valid && !start;
    cmp_valid = dly_valid && !start;
    cmp_fail  = cmp_valid && (z != exp_dly);

    state_d   = state_q;
    op_d      = op_q;
    vec_cnt_d = vec_cnt_q;
    cmp_cnt_d = cmp_cnt_q;
    err_cnt_d = err_cnt_q;
    fidx_d    = fidx_q;
    fexp_d    = fexp_q;
    fgot_d    = fgot_q;
    mism_d    = cmp_fail;
    done_d    = (state_q == ST_DONE);
    // Verdict is registered off the final err_cnt, one edge after DONE entry.
    pass_d    = (state_q == ST_DONE) && (err_cnt_q == '0);

    if (start) begin
      state_d   = ST_RUN;
      op_d      = op;
      vec_cnt_d = '0;
      cmp_cnt_d = '0;
      err_cnt_d = '0;
      fidx_d    = '0;
      fexp_d    = '0;
      fgot_d    = '0;
      mism_d    = 1'b0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept && vec_cnt_q == 16'(NUM_VECTORS - 1))
            state_d = (LATENCY == 0) ? ST_DONE : ST_DRAIN;
        end
        ST_DRAIN: begin
          if (cmp_valid && cmp_cnt_q == 16'(NUM_VECTORS - 1)) state_d = ST_DONE;
        end
        default: ;
      endcase
      if (accept)    vec_cnt_d = vec_cnt_q + 16'd1;
      if (cmp_valid) cmp_cnt_d = cmp_cnt_q + 16'd1;
      if (cmp_fail) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
        if (err_cnt_q == '0) begin
          fidx_d = cmp_cnt_q;
          fexp_d = exp_dly;
          fgot_d = z;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      vec_cnt_q <= '0;
      cmp_cnt_q <= '0;
      err_cnt_q <= '0;
      fidx_q    <= '0;
      fexp_q    <= '0;
      fgot_q    <= '0;
      mism_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      vec_cnt_q <= vec_cnt_d;
      cmp_cnt_q <= cmp_cnt_d;
      err_cnt_q <= err_cnt_d;
      fidx_q    <= fidx_d;
      fexp_q    <= fexp_d;
      fgot_q    <= fgot_d;
      mism_q    <= mism_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done          = done_q;
  assign pass          = pass_q;
  assign mismatch      = mism_q;
  assign vec_cnt       = vec_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = fidx_q;
  assign first_err_exp = fexp_q;
  assign first_err_got = fgot_q;

endmodule

// File: tb/tb_gate_resp_checker.sv
// Scoreboard bench for gate_resp_checker: one LATENCY=1 and one LATENCY=0
// instance, driven by an emulated gate with optional injected output errors.
module tb_gate_resp_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  start;
  logic [2:0]  op;
  logic        in_valid;
  logic [4:0]  a, b;
  logic [5:0]  emask;
  logic [5:0]  z0, z1;

  logic [1:0]  busy, done, pass, mism;
  logic [15:0] vec_cnt [2];
  logic [15:0] err_cnt [2];
  logic [15:0] fidx [2];
  logic [5:0]  fexp [2];
  logic [5:0]  fgot [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc [2];
  int mmc [2];
  logic [1:0] done_prev = 2'b00;

  typedef struct {
    int         vec;
    int         errs;
    int         idx;
    logic [5:0] fe;
    logic [5:0] fg;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  logic [4:0] va [10];
  logic [4:0] vb [10];
  logic [5:0] vm [10];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Truth table of the gate family, straight from the op list.
  function automatic logic [5:0] ref_gate(input logic [2:0] o, input logic [4:0] x, input logic [4:0] y);
    case (o)
      3'd1:    return {1'b0, x | y};
      3'd2:    return {1'b0, x ^ y};
      3'd3:    return {1'b0, ~(x & y)};
      3'd4:    return {1'b0, ~(x | y)};
      3'd5:    return {1'b0, ~(x ^ y)};
      3'd6:    return 6'(int'(x) + int'(y));
      default: return {1'b0, x & y};
    endcase
  endfunction

  // Emulated gates under test; emask injects output errors.
  assign z0 = ref_gate(op, a, b) ^ emask;
  always @(posedge clk) z1 <= ref_gate(op, a, b) ^ emask;

  gate_resp_checker #(.WIDTH(5), .LATENCY(0), .NUM_VECTORS(10)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .op(op), .in_valid(in_valid),
    .a(a), .b(b), .z(z0), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .mismatch(mism[0]), .vec_cnt(vec_cnt[0]), .err_cnt(err_cnt[0]),
    .first_err_idx(fidx[0]), .first_err_exp(fexp[0]), .first_err_got(fgot[0]));

  gate_resp_checker #(.WIDTH(5), .LATENCY(1), .NUM_VECTORS(10)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .op(op), .in_valid(in_valid),
    .a(a), .b(b), .z(z1), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .mismatch(mism[1]), .vec_cnt(vec_cnt[1]), .err_cnt(err_cnt[1]),
    .first_err_idx(fidx[1]), .first_err_exp(fexp[1]), .first_err_got(fgot[1]));

  task automatic chk(input string nm, input int s, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h, required %0h", nm, s, got, exp);
    end
  endtask

  function automatic int qsize(input int s);
    return (s == 0) ? q0.size() : q1.size();
  endfunction

  // Monitor: pops the expected run result whenever a verdict appears.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    for (int s = 0; s < 2; s++) begin
      if (start[s]) mmc[s] = 0;
      else if (mism[s] === 1'b1) mmc[s]++;
      if (done[s] === 1'b1 && done_prev[s] !== 1'b1) begin
        have = 1'b0;
        if (s == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        if (s == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        if (!have) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done dut%0d: got done=1, required no verdict", s);
        end else begin
          chk("vec_cnt",       s, 64'(vec_cnt[s]), 64'(e.vec));
          chk("err_cnt",       s, 64'(err_cnt[s]), 64'(e.errs));
          chk("pass",          s, 64'(pass[s]),    64'(e.errs == 0));
          chk("first_err_idx", s, 64'(fidx[s]),    64'(e.idx));
          chk("first_err_exp", s, 64'(fexp[s]),    64'(e.fe));
          chk("first_err_got", s, 64'(fgot[s]),    64'(e.fg));
          chk("mismatch_pulses", s, 64'(mmc[s]),   64'(e.errs));
          chk("done_latency",  s, 64'(cyc - last_acc[s]), 64'((s == 0) ? 1 : 2));
        end
      end
      done_prev[s] = done[s];
    end
  end

  task automatic fill_random(input bit with_err);
    for (int i = 0; i < 10; i++) begin
      va[i] = 5'($urandom);
      vb[i] = 5'($urandom);
      vm[i] = (with_err && $urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'h00;
    end
  endtask

  task automatic do_run(input int s, input logic [2:0] o, input int gapmode,
                        input int extras, input bit vws);
    exp_t       e;
    logic [5:0] x;
    int         g;
    int         t;
    e.vec = 10; e.errs = 0; e.idx = 0; e.fe = '0; e.fg = '0;
    for (int i = 0; i < 10; i++) begin
      x = ref_gate(o, va[i], vb[i]);
      if (vm[i] != 6'h00) begin
        if (e.errs == 0) begin e.idx = i; e.fe = x; e.fg = x ^ vm[i]; end
        e.errs++;
      end
    end
    if (s == 0) q0.push_back(e); else q1.push_back(e);

    @(posedge clk); #1;
    start[s] = 1'b1; op = o; in_valid = vws;
    a = 5'($urandom); b = 5'($urandom); emask = vws ? 6'h3F : 6'h00;
    @(posedge clk); #1;
    start[s] = 1'b0;
    chk("busy_after_start",    s, 64'(busy[s]),    64'd1);
    chk("vec_cnt_after_start", s, 64'(vec_cnt[s]), 64'd0);
    chk("err_cnt_after_start", s, 64'(err_cnt[s]), 64'd0);
    chk("done_after_start",    s, 64'(done[s]),    64'd0);

    for (int i = 0; i < 10; i++) begin
      g = (gapmode == 1) ? int'(i > 0) : (gapmode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (g) begin
        in_valid = 1'b0; emask = 6'h00;
        @(posedge clk); #1;
      end
      in_valid = 1'b1; a = va[i]; b = vb[i]; emask = vm[i];
      if (i == 9) last_acc[s] = cyc + 1;
      @(posedge clk); #1;
    end
    for (int k = 0; k < extras; k++) begin
      in_valid = 1'b1; a = 5'($urandom); b = 5'($urandom);
      emask = 6'($urandom_range(1, 63));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; emask = 6'h00;

    t = 0;
    while (qsize(s) != 0 && t < 40) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (qsize(s) != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout dut%0d: got no done within 40 cycles, required done", s);
      if (s == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
  endtask

  task automatic mid_reset();
    @(posedge clk); #1;
    start[1] = 1'b1; op = 3'($urandom_range(0, 7)); in_valid = 1'b0;
    @(posedge clk); #1;
    start[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = 5'($urandom); b = 5'($urandom);
      emask = (i == 1) ? 6'h01 : 6'h00;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; emask = 6'h00;
    #2;
    rst_n = 1'b0;
    #1;
    chk("outputs_in_async_reset", 1,
        {busy[1], done[1], pass[1], mism[1], vec_cnt[1], err_cnt[1], fidx[1], fexp[1], fgot[1]},
        64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 2'b00; op = 3'd0; in_valid = 1'b0;
    a = '0; b = '0; emask = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++)
      chk("reset_state", s,
          {busy[s], done[s], pass[s], mism[s], vec_cnt[s], err_cnt[s], fidx[s], fexp[s], fgot[s]},
          64'd0);
    rst_n = 1'b1;
    // Valid vectors while IDLE must be ignored.
    in_valid = 1'b1; a = 5'h1F; b = 5'h1F;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int s = 0; s < 2; s++) begin
      chk("idle_vec_cnt", s, 64'(vec_cnt[s]), 64'd0);
      chk("idle_busy",    s, 64'(busy[s]),    64'd0);
    end

    fill_random(1'b0); va[0] = 5'h1F; vb[0] = 5'h15;
    do_run(1, 3'd0, 0, 0, 1'b0);

    fill_random(1'b0); va[3] = 5'h0C; vb[3] = 5'h0A; vm[3] = 6'h01;
    do_run(1, 3'd0, 0, 0, 1'b0);

    fill_random(1'b0);
    va[0] = 5'h1F; vb[0] = 5'h01;
    va[1] = 5'h1F; vb[1] = 5'h01; vm[1] = 6'h20;
    do_run(1, 3'd6, 0, 0, 1'b0);

    fill_random(1'b0); va[0] = 5'h1F; vb[0] = 5'h1F; vm[0] = 6'h20;
    do_run(1, 3'd3, 0, 0, 1'b0);

    fill_random(1'b1);
    do_run(1, 3'($urandom_range(0, 7)), 1, 3, 1'b0);

    mid_reset();
    fill_random(1'b0);
    do_run(1, 3'd2, 0, 0, 1'b0);

    fill_random(1'b0); vm[2] = 6'h01; vm[7] = 6'h20;
    do_run(0, 3'd1, 0, 0, 1'b0);
    fill_random(1'b1);
    do_run(0, 3'd5, 0, 2, 1'b1);

    for (int r = 0; r < 8; r++) begin
      fill_random(1'b1);
      do_run(r % 2, 3'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gate_resp_checker.md
Name: gate_resp_checker

Overview:
- Self-checking response end for the combinational gate blocks (AND and its siblings).
- Stimulus side drives operands `a` and `b` into the gate under test. This block receives the same operands with a valid strobe, plus the gate's `z` output.
- It computes the expected result and aligns it to the gate's latency. It compares, counts and captures the first mismatch, then reports a pass/fail verdict after a fixed vector count.
- Synthesisable, so it can sit on-chip as a BIST monitor or in a bench.

Parameters:
- `WIDTH`, 5, operand width; `z` is `WIDTH+1` bits.
- `LATENCY`, 1, gate latency in cycles from operand to `z` (legal range 0..7).
- `NUM_VECTORS`, 10, accepted vectors per run before the verdict.

Ports:
- `clk`  input  1  system clock, rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `start`  input  1  one-cycle pulse; clears state and arms a run.
- `op`  input  3  operation; sampled only on `start`.
- `in_valid`  input  1  `a`/`b` valid this cycle.
- `a`  input  `WIDTH`  operand A.
- `b`  input  `WIDTH`  operand B.
- `z`  input  `WIDTH+1`  gate output under check.
- `busy`  output  1  run in progress (RUN or DRAIN).
- `done`  output  1  verdict valid; held until `start` or reset.
- `pass`  output  1  valid when `done`; 1 iff `err_cnt`==0.
- `mismatch`  output  1  one-cycle pulse, registered, cycle after a failing compare.
- `vec_cnt`  output  16  vectors accepted this run.
- `err_cnt`  output  16  failing compares; saturates at 16'hFFFF.
- `first_err_idx`  output  16  index (0-based) of first failing vector.
- `first_err_exp`  output  `WIDTH+1`  expected value at first failure.
- `first_err_got`  output  `WIDTH+1`  observed `z` at first failure.

Behaviour:
- **Clock and reset:** one clock domain, `clk`. Reset is asynchronous and active-low on `rst_n`.
- **Reset values:** all outputs 0, state IDLE, delay line empty, latched `op`=0.
- **Op encoding:**
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ADD, 7 reserved (behaves as AND).
  - Bitwise ops: expected = `{1'b0, f(a,b)}`; the MSB must be 0.
  - ADD: expected = `a+b` zero-extended, carry in the MSB.
- **States:** IDLE, RUN, DRAIN, DONE. `start` in any state has priority:
  - clears counters, `first_err_*`, `done`/`pass`/`mismatch` and the delay line;
  - latches `op`;
  - enters RUN on that edge, so `busy`=1 the next cycle.
- **IDLE:** `in_valid` is ignored.
- **RUN:**
  - A vector is accepted on a rising edge with `in_valid`=1. `vec_cnt` increments and the expected value plus a valid bit enter the `LATENCY`-stage delay line.
  - The edge accepting vector `NUM_VECTORS-1` moves the state to DRAIN.
- **Compare timing:**
  - A compare occurs on the edge where the delay-line output is valid; `z` is sampled at that edge.
  - With `LATENCY`=0 the compare uses the current `a`/`b`/`z` on the accept edge.
  - Compare index = running compare count.
- **On mismatch:**
  - `err_cnt` += 1 (saturating) and `mismatch`=1 for the next cycle.
  - If `err_cnt` was 0, capture `first_err_idx`/`first_err_exp`/`first_err_got`. They are never overwritten within a run.
- **DRAIN:**
  - `in_valid` is ignored and no new vectors are accepted.
  - Moves to DONE on the edge of the final compare. With `LATENCY`=0 this is immediate: RUN goes directly to DONE on the last accept edge.
- **DONE:** `done`=1 and `pass`=(`err_cnt`==0), registered, `busy`=0. Holds until `start`.
- **Reset mid-run:** immediate return to reset values; the next `start` behaves normally.
- **Simultaneous `start` and `in_valid`:** the vector is not accepted (restart wins).
- **`vec_cnt` range:** never exceeds `NUM_VECTORS`.

Decomposition:
- **`gate_chk_pkg`:** op code localparams (`OP_AND`..`OP_ADD`), state encodings, and a function `gate_expected(op,a,b)` returning the `WIDTH+1` result.
- **`gate_chk_delay`:** the one sub-module. A `LATENCY`-stage shift register of {valid, expected}, flushed by `start`; with `LATENCY`=0 it is a pass-through.

Test Plan:
1. `WIDTH`=5, `LATENCY`=1, `op`=0, correct AND model, 10 back-to-back vectors (e.g. `a`=5'h1F, `b`=5'h15 → `z`=6'h15) → `done`=1 two cycles after the 10th accept edge, `pass`=1, `vec_cnt`=10, `err_cnt`=0, `mismatch` never high.
2. Same run, but vector 3 (`a`=5'h0C, `b`=5'h0A) has `z` forced to 6'h09 → `mismatch` pulse once, `err_cnt`=1, `first_err_idx`=3, `first_err_exp`=6'h08, `first_err_got`=6'h09, `pass`=0.
3. `op`=6 (ADD), `a`=5'h1F, `b`=5'h01: `z`=6'h20 → no error; `z`=6'h00 → mismatch with exp 6'h20. Also NAND `a`=`b`=5'h1F with `z`=6'h20 → mismatch (MSB must be 0).
4. `in_valid` high every other cycle, plus 3 extra valids after the 10th → `vec_cnt` stops at 10 and extras produce no compares.
5. `rst_n` low asynchronously after 4 accepts → all outputs 0 before the next edge; then `start` runs a clean pass to `done`=1, `pass`=1.
6. `LATENCY`=0 build, and `start` asserted while in DONE with `err_cnt`=2 → counters clear, `busy`=1 next cycle; a `start`+`in_valid` cycle is not counted.
